// File: rtl/amplitude_ram_arbiter.sv
// amplitude_ram_arbiter: round-robin owner arbitration of one amplitude RAM between two requesters,
// with a one-cycle drain for the trailing write of a read-modify-write and a sticky violation flag.
module amplitude_ram_arbiter #(
   parameter int num_qubit   = 4,
   parameter int complex_bit = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req0,
   input  logic                     req1,
   output logic                     gnt0,
   output logic                     gnt1,
   input  logic                     rd_en0,
   input  logic                     rd_en1,
   input  logic [num_qubit-1:0]     rd_addr0,
   input  logic [num_qubit-1:0]     rd_addr1,
   input  logic                     wr_en0,
   input  logic                     wr_en1,
   input  logic [num_qubit-1:0]     wr_addr0,
   input  logic [num_qubit-1:0]     wr_addr1,
   input  logic [2*complex_bit-1:0] wr_data0,
   input  logic [2*complex_bit-1:0] wr_data1,
   output logic                     ram_rd_en,
   output logic [num_qubit-1:0]     ram_rd_addr,
   output logic                     ram_wr_en,
   output logic [num_qubit-1:0]     ram_wr_addr,
   output logic [2*complex_bit-1:0] ram_wr_data,
   input  logic [2*complex_bit-1:0] ram_rd_data,
   output logic [2*complex_bit-1:0] rd_data,
   output logic                     busy,
   output logic                     violation
);
   typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} state_t;
   state_t state, next;
   logic last_owner, wsel0, wsel1, bad;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state      <= IDLE;
         last_owner <= 1'b1;
         violation  <= 1'b0;
      end else begin
         state     <= next;
         violation <= violation | bad;
         if (state == IDLE && next != IDLE) last_owner <= (next == OWN1);
      end

   // round-robin: on contention the requester that did not own last time wins
   always_comb begin
      next = state;
      case (state)
         IDLE:    next = (req0 && (!req1 || last_owner)) ? OWN0 : req1 ? OWN1 : IDLE;
         OWN0:    next = req0 ? OWN0 : DRAIN;
         OWN1:    next = req1 ? OWN1 : DRAIN;
         default: next = IDLE;
      endcase
   end

   // the write port stays with the previous owner through DRAIN; the read port does not
   assign gnt0        = (state == OWN0);
   assign gnt1        = (state == OWN1);
   assign busy        = (state != IDLE);
   assign wsel0       = gnt0 || (state == DRAIN && !last_owner);
   assign wsel1       = gnt1 || (state == DRAIN && last_owner);
   assign ram_rd_en   = gnt0 ? rd_en0 : gnt1 ? rd_en1 : 1'b0;
   assign ram_rd_addr = gnt0 ? rd_addr0 : gnt1 ? rd_addr1 : '0;
   assign ram_wr_en   = wsel0 ? wr_en0 : wsel1 ? wr_en1 : 1'b0;
   assign ram_wr_addr = wsel0 ? wr_addr0 : wsel1 ? wr_addr1 : '0;
   assign ram_wr_data = wsel0 ? wr_data0 : wsel1 ? wr_data1 : '0;
   assign rd_data     = ram_rd_data;
   assign bad         = (rd_en0 & ~gnt0) | (rd_en1 & ~gnt1) | (wr_en0 & ~wsel0) | (wr_en1 & ~wsel1);
endmodule

// File: tb/tb_amplitude_ram_arbiter.sv
// tb_amplitude_ram_arbiter: vector table, directed corner sequences and a randomized run
// against an ownership-level reference model of the RAM arbiter.
module tb_amplitude_ram_arbiter;
   localparam int NQ = 4;
   localparam int DW = 48;

   logic clk, rst;
   logic [1:0] req, rd_en, wr_en;
   logic [NQ-1:0] rd_addr [2];
   logic [NQ-1:0] wr_addr [2];
   logic [DW-1:0] wr_data [2];
   logic gnt0, gnt1, ram_rd_en, ram_wr_en, busy, violation;
   logic [NQ-1:0] ram_rd_addr, ram_wr_addr;
   logic [DW-1:0] ram_wr_data, ram_rd_data, rd_data;

   amplitude_ram_arbiter #(.num_qubit(NQ), .complex_bit(DW/2)) dut (
      .clk(clk), .rst(rst), .req0(req[0]), .req1(req[1]), .gnt0(gnt0), .gnt1(gnt1),
      .rd_en0(rd_en[0]), .rd_en1(rd_en[1]), .rd_addr0(rd_addr[0]), .rd_addr1(rd_addr[1]),
      .wr_en0(wr_en[0]), .wr_en1(wr_en[1]), .wr_addr0(wr_addr[0]), .wr_addr1(wr_addr[1]),
      .wr_data0(wr_data[0]), .wr_data1(wr_data[1]),
      .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_wr_en(ram_wr_en),
      .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data),
      .rd_data(rd_data), .busy(busy), .violation(violation));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int passed = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [DW-1:0] rnd48();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[DW-1:0];
   endfunction

   task automatic clear_inputs();
      req = '0; rd_en = '0; wr_en = '0;
      for (int i = 0; i < 2; i++) begin
         rd_addr[i] = '0; wr_addr[i] = '0; wr_data[i] = '0;
      end
      ram_rd_data = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear_inputs();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ctl = {rst,req0,req1,rd_en0,wr_en0,rd_en1,wr_en1}; flags = {gnt0,gnt1,busy,violation,ram_rd_en,ram_wr_en}
   typedef struct {
      logic [6:0]    ctl;
      logic [NQ-1:0] ra0, wa0, wa1;
      logic [5:0]    flags;
      logic [NQ-1:0] rwa;
   } vec_t;
   vec_t vt [19];

   // reference model: who owns the RAM, whether a drain cycle is pending, who owned last
   int owner, prev;
   bit drain, mviol;

   task automatic model_reset();
      owner = -1; drain = 1'b0; prev = 1; mviol = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vt[0]  = '{7'b1110000, 4'd0, 4'd0, 4'd0, 6'b000000, 4'd0};
      vt[1]  = '{7'b0110000, 4'd0, 4'd0, 4'd0, 6'b000000, 4'd0};
      vt[2]  = '{7'b0111001, 4'd2, 4'd0, 4'd5, 6'b101010, 4'd0};
      vt[3]  = '{7'b0110100, 4'd0, 4'd7, 4'd0, 6'b101101, 4'd7};
      vt[4]  = '{7'b0011100, 4'd3, 4'd2, 4'd0, 6'b101111, 4'd2};
      vt[5]  = '{7'b0010100, 4'd0, 4'd3, 4'd0, 6'b001101, 4'd3};
      vt[6]  = '{7'b0010000, 4'd0, 4'd0, 4'd0, 6'b000100, 4'd0};
      vt[7]  = '{7'b0010001, 4'd0, 4'd0, 4'd4, 6'b011101, 4'd4};
      vt[8]  = '{7'b1010001, 4'd0, 4'd0, 4'd4, 6'b000000, 4'd0};
      vt[9]  = '{7'b0010000, 4'd0, 4'd0, 4'd0, 6'b000000, 4'd0};
      vt[10] = '{7'b0010000, 4'd0, 4'd0, 4'd0, 6'b011000, 4'd0};
      vt[11] = '{7'b0110000, 4'd0, 4'd0, 4'd0, 6'b011000, 4'd0};
      vt[12] = '{7'b0100000, 4'd0, 4'd0, 4'd0, 6'b011000, 4'd0};
      vt[13] = '{7'b0100000, 4'd0, 4'd0, 4'd0, 6'b001000, 4'd0};
      vt[14] = '{7'b0110000, 4'd0, 4'd0, 4'd0, 6'b000000, 4'd0};
      vt[15] = '{7'b0010000, 4'd0, 4'd0, 4'd0, 6'b101000, 4'd0};
      vt[16] = '{7'b0011000, 4'd1, 4'd0, 4'd0, 6'b001000, 4'd0};
      vt[17] = '{7'b0010000, 4'd0, 4'd0, 4'd0, 6'b000100, 4'd0};
      vt[18] = '{7'b0010000, 4'd0, 4'd0, 4'd0, 6'b011100, 4'd0};

      rst = 1'b1;
      clear_inputs();
      for (int v = 0; v < 19; v++) begin
         @(negedge clk);
         {rst, req[0], req[1], rd_en[0], wr_en[0], rd_en[1], wr_en[1]} = vt[v].ctl;
         rd_addr[0] = vt[v].ra0; wr_addr[0] = vt[v].wa0; wr_addr[1] = vt[v].wa1;
         #1;
         check($sformatf("vec%0d", v), {gnt0, gnt1, busy, violation, ram_rd_en, ram_wr_en, ram_wr_addr},
               {vt[v].flags, vt[v].rwa});
      end

      // pipelined read-modify-write: last write lands in DRAIN, read port closed
      do_reset();
      req[0] = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         rd_en[0] = 1'b1; rd_addr[0] = NQ'(c);
         wr_en[0] = (c > 0); wr_addr[0] = NQ'(c - 1); wr_data[0] = 48'hA00000 + 48'(c);
         req[0] = (c < 3);
         #1;
         check($sformatf("rmw_rd%0d", c), {gnt0, ram_rd_en, ram_rd_addr}, {1'b1, 1'b1, NQ'(c)});
      end
      @(negedge clk);
      rd_en[0] = 1'b0; wr_en[0] = 1'b1; wr_addr[0] = 4'd3; wr_data[0] = 48'hA00003;
      #1;
      check("rmw_drain", {gnt0, busy, ram_rd_en, ram_wr_en, ram_wr_addr, ram_wr_data},
            {1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 48'hA00003});
      @(negedge clk);
      wr_en[0] = 1'b0;
      #1;
      check("rmw_noviol", {busy, violation}, 2'b00);

      // 16-word sweep with wrap, read data forwarded unchanged
      do_reset();
      req[0] = 1'b1;
      for (int a = 0; a < 18; a++) begin
         logic [DW-1:0] d;
         logic [4:0] full;
         @(negedge clk);
         full = 5'(a);
         d = rnd48();
         rd_en[0] = 1'b1; rd_addr[0] = full[3:0]; ram_rd_data = d;
         #1;
         check($sformatf("sweep%0d", a), {ram_rd_en, ram_rd_addr, rd_data}, {1'b1, NQ'(a % 16), d});
      end

      // alternating contention: both requests held, each owner drops after two cycles
      do_reset();
      req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         int n = 0;
         int own;
         do begin
            @(negedge clk); #1; n++;
         end while (!(gnt0 | gnt1) && n < 8);
         check($sformatf("rr%0d", k), {gnt1, gnt0, busy}, {(k % 2 == 1), (k % 2 == 0), 1'b1});
         own = k % 2;
         @(negedge clk);
         @(negedge clk); req[own] = 1'b0;
         @(negedge clk); req[own] = 1'b1;
         #1;
         check($sformatf("rr_drain%0d", k), {gnt1, gnt0, busy}, 3'b001);
      end

      // randomized run against the ownership model
      do_reset();
      model_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         int w;
         logic e_rre, e_rwe;
         logic [NQ-1:0] e_rra, e_rwa;
         logic [DW-1:0] e_rwd;
         @(negedge clk);
         rst = ($urandom_range(0, 39) == 0);
         for (int i = 0; i < 2; i++) begin
            if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
            rd_en[i] = ($urandom_range(0, 2) == 0);
            wr_en[i] = ($urandom_range(0, 2) == 0);
            rd_addr[i] = NQ'($urandom_range(0, 15));
            wr_addr[i] = NQ'($urandom_range(0, 15));
            wr_data[i] = rnd48();
         end
         ram_rd_data = rnd48();
         #1;
         if (rst) model_reset();
         w = owner >= 0 ? owner : (drain ? prev : -1);
         e_rre = owner >= 0 ? rd_en[owner] : 1'b0;
         e_rra = owner >= 0 ? rd_addr[owner] : '0;
         e_rwe = w >= 0 ? wr_en[w] : 1'b0;
         e_rwa = w >= 0 ? wr_addr[w] : '0;
         e_rwd = w >= 0 ? wr_data[w] : '0;
         check($sformatf("rand%0d", cyc),
               {gnt0, gnt1, busy, violation, ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data, rd_data},
               {owner == 0, owner == 1, (owner >= 0) || drain, mviol, e_rre, e_rra, e_rwe, e_rwa, e_rwd, ram_rd_data});
         if (!rst) begin
            for (int i = 0; i < 2; i++)
               if ((rd_en[i] && owner != i) || (wr_en[i] && w != i)) mviol = 1'b1;
            if (owner >= 0) begin
               if (!req[owner]) begin drain = 1'b1; owner = -1; end
            end else if (drain) drain = 1'b0;
            else if (req == 2'b11) begin owner = 1 - prev; prev = owner; end
            else if (req != 2'b00) begin owner = req[1] ? 1 : 0; prev = owner; end
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/amplitude_ram_arbiter.md
AMPLITUDE_RAM_ARBITER -- requirements
Module: amplitude_ram_arbiter

Interface
REQ-001 Parameter num_qubit, default 4: RAM address width; the RAM has 2^num_qubit entries.
REQ-002 Parameter complex_bit, default 24: width of each real/imag half; a RAM word is 2*complex_bit bits, {real, imag}.
REQ-003 Clocking: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req0, req1  input  1 each  access request from requester 0 (beta updater) and requester 1 (amplitude readout/loader).
REQ-007 gnt0, gnt1  output  1 each  registered grant to the matching requester.
REQ-008 rd_en0, rd_en1  input  1 each  requester read strobe.
REQ-009 rd_addr0, rd_addr1  input  num_qubit each  requester read address.
REQ-010 wr_en0, wr_en1  input  1 each  requester write strobe.
REQ-011 wr_addr0, wr_addr1  input  num_qubit each  requester write address.
REQ-012 wr_data0, wr_data1  input  2*complex_bit each  requester write data.
REQ-013 ram_rd_en, ram_rd_addr  output  1, num_qubit  RAM read port.
REQ-014 ram_wr_en, ram_wr_addr, ram_wr_data  output  1, num_qubit, 2*complex_bit  RAM write port.
REQ-015 ram_rd_data  input  2*complex_bit  RAM read data, one-cycle read latency.
REQ-016 rd_data  output  2*complex_bit  ram_rd_data forwarded unchanged to both requesters.
REQ-017 busy  output  1  high whenever state is not IDLE.
REQ-018 violation  output  1  sticky flag for a suppressed access.

Function
REQ-019 States: IDLE, OWN0, OWN1, DRAIN; register last_owner is 1 bit.
REQ-020 In IDLE, gnt0=gnt1=0; with only reqX high, the next state is OWNX.
REQ-021 In IDLE with req0 and req1 both high, the grant goes to the requester not equal to last_owner (round-robin).
REQ-022 Grant latency: a request sampled in IDLE at edge n gives gntX=1 from edge n+1 to the end of OWNX.
REQ-023 On entry to OWNX, last_owner is set to X.
REQ-024 In OWNX, all RAM ports are driven combinationally from requester X.
REQ-025 In OWNX, requester X holds ownership while reqX stays high; the other request has no effect.
REQ-026 In OWNX, reqX sampled low moves the state to DRAIN, and gntX deasserts at that edge.
REQ-027 DRAIN lasts exactly one cycle and then returns to IDLE; it covers the write trailing the last read (pipelined read-modify-write).
REQ-028 In DRAIN, only the write port of the previous owner is routed (wr_en/addr/data); ram_rd_en is forced to 0.
REQ-029 Arbitration happens only in IDLE, so the minimum gap between two ownerships is DRAIN plus IDLE, 2 cycles.
REQ-030 Idle routing: with no owner (IDLE, and the DRAIN read port), enables are 0, addresses are 0 and ram_wr_data is 0.
REQ-031 Suppression: rd_en or wr_en asserted by a non-owner is blocked from the RAM and sets violation to 1 at the next edge.
REQ-032 In DRAIN, a read from the previous owner also counts as a non-owner access.
REQ-033 violation is cleared only by rst.
REQ-034 Data is passed through with no arithmetic and no width change.
REQ-035 Simultaneous events: reqX falling in the same cycle that the other requester rises still goes through DRAIN and IDLE before the new grant.

Reset
REQ-036 rst asserted at any time, including mid-ownership, immediately forces: state=IDLE, gnt0=gnt1=0, last_owner=1, violation=0, busy=0.
REQ-037 While rst is high, ram_rd_en=0 and ram_wr_en=0.
REQ-038 An in-flight write in DRAIN is dropped on reset.
REQ-039 After reset release with req0 and req1 both high, req0 wins (last_owner=1).

Verification
REQ-040 Reset release, req0=req1=1 at edge 0 -> gnt0=1 at edge 1. Drop req0 -> DRAIN, then IDLE, then gnt1=1 two cycles after DRAIN.
REQ-041 Requester 0 reads addresses 0..3 with writes delayed one cycle, then drops req0 on the last read -> wr to address 3 reaches RAM in DRAIN, and ram_rd_en=0 in DRAIN.
REQ-042 During OWN0, requester 1 asserts wr_en1 to address 5 -> ram_wr_en reflects only requester 0, and violation=1 next edge and stays 1.
REQ-043 rst pulsed during OWN1 with wr_en1=1 -> ram_wr_en=0 immediately, gnt1=0, violation=0, state IDLE.
REQ-044 req0 only, 16-word sweep, num_qubit=4 -> ram_rd_addr wraps 0..15, and rd_data equals ram_rd_data each cycle.
REQ-045 Alternating contention (both requests held, each owner drops after 2 cycles) -> grants alternate 0,1,0,1 and busy stays high except the IDLE cycles.
